// File: rtl/loop_chk_pkg.sv
// loop_chk_pkg: shared states, constants and width helpers for the loop sum checker
package loop_chk_pkg;
    typedef enum logic [1:0] {MONITOR, COMPARE, REPORT, WAIT_RESTART} state_t;
    localparam int STEP_INC  = 3;
    localparam int EXP_MUL   = 3;
    localparam int DEF_W     = 11;
    localparam int DEF_CNT_W = 8;
    function automatic int sum_width(input int w);
        return w + 2;
    endfunction
endpackage

// File: rtl/loop_step_monitor.sv
// loop_step_monitor: remembers the previous loop sample and flags illegal per-step sum changes (sticky until rst)
module loop_step_monitor
    import loop_chk_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      loop_rst_i,
    input  logic                      monitor_i,
    input  logic [W-1:0]              i_i,
    input  logic [W-1:0]              n_i,
    input  logic [sum_width(W)-1:0]   sum_i,
    output logic                      step_err_o
);
    localparam int SW = sum_width(W);
    logic          prev_valid_q, prev_valid_d;
    logic [W-1:0]  prev_i_q, prev_i_d, prev_n_q, prev_n_d;
    logic [SW-1:0] prev_sum_q, prev_sum_d;
    logic          step_err_q, step_err_d;
    logic          sample, armed, is_inc, is_hold, viol;

    // compare the current sample against the previous one and update history
    always_comb begin
        sample       = monitor_i && !loop_rst_i;
        armed        = sample && prev_valid_q && (prev_i_q < prev_n_q);
        is_inc       = {1'b0, i_i} == {1'b0, prev_i_q} + (W+1)'(1);
        is_hold      = i_i == prev_i_q;
        viol         = armed && (is_inc  ? sum_i != prev_sum_q + SW'(STEP_INC) :
                                 is_hold ? sum_i != prev_sum_q : 1'b1);
        prev_valid_d = loop_rst_i ? 1'b0 : sample ? 1'b1 : prev_valid_q;
        prev_i_d     = monitor_i ? i_i   : prev_i_q;
        prev_n_d     = monitor_i ? n_i   : prev_n_q;
        prev_sum_d   = monitor_i ? sum_i : prev_sum_q;
        step_err_d   = step_err_q | viol;
    end

    // history and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid_q <= 1'b0;
            prev_i_q     <= '0;
            prev_n_q     <= '0;
            prev_sum_q   <= '0;
            step_err_q   <= 1'b0;
        end else begin
            prev_valid_q <= prev_valid_d;
            prev_i_q     <= prev_i_d;
            prev_n_q     <= prev_n_d;
            prev_sum_q   <= prev_sum_d;
            step_err_q   <= step_err_d;
        end
    end

    assign step_err_o = step_err_q;
endmodule

// File: rtl/loop_sum_checker.sv
// loop_sum_checker: detects loop completion, checks x+y == 3*n and reports the verdict over valid/ready (step checker under STEP_CHECK_EN)
module loop_sum_checker
    import loop_chk_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loop_rst,
    input  logic [W-1:0]     x_in,
    input  logic [W-1:0]     y_in,
    input  logic [W-1:0]     i_in,
    input  logic [W-1:0]     n_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_pass,
    output logic [W+1:0]     res_sum,
    output logic [W+1:0]     res_expect,
    output logic             step_err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);
    localparam int SW = sum_width(W);
    state_t           state_q, state_d;
    logic             valid_q, valid_d, pass_q, pass_d;
    logic [SW-1:0]    sum_q, sum_d, exp_q, exp_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic [SW-1:0]    sum, expect_v;
    logic             done, acc;

    assign sum      = SW'(x_in) + SW'(y_in);
    assign expect_v = SW'(EXP_MUL) * SW'(n_in);
    assign done     = (i_in >= n_in) && !loop_rst;
    assign acc      = valid_q && res_ready && !loop_rst;

    // verdict FSM next state; loop_rst re-arms from any state and drops an unaccepted verdict
    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        pass_d  = pass_q;
        sum_d   = sum_q;
        exp_d   = exp_q;
        case (state_q)
            MONITOR: if (done) begin
                state_d = COMPARE;
                sum_d   = sum;
                exp_d   = expect_v;
            end
            COMPARE: begin
                pass_d  = sum_q == exp_q;
                state_d = REPORT;
            end
            REPORT: begin
                valid_d = !acc;
                state_d = acc ? WAIT_RESTART : REPORT;
            end
            default: ;
        endcase
        if (loop_rst) begin
            state_d = MONITOR;
            valid_d = 1'b0;
        end
    end

    // saturating run counters advance only on an accepted verdict
    always_comb begin
        pass_cnt_d = (acc &&  pass_q && !(&pass_cnt_q)) ? pass_cnt_q + CNT_W'(1) : pass_cnt_q;
        fail_cnt_d = (acc && !pass_q && !(&fail_cnt_q)) ? fail_cnt_q + CNT_W'(1) : fail_cnt_q;
    end

    // state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MONITOR;
            valid_q    <= 1'b0;
            pass_q     <= 1'b0;
            sum_q      <= '0;
            exp_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pass_q     <= pass_d;
            sum_q      <= sum_d;
            exp_q      <= exp_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

`ifdef STEP_CHECK_EN
    loop_step_monitor #(.W(W)) u_step (
        .clk        (clk),
        .rst        (rst),
        .loop_rst_i (loop_rst),
        .monitor_i  (state_q == MONITOR),
        .i_i        (i_in),
        .n_i        (n_in),
        .sum_i      (sum),
        .step_err_o (step_err)
    );
`else
    assign step_err = 1'b0;
`endif

    assign res_valid  = valid_q;
    assign res_pass   = pass_q;
    assign res_sum    = sum_q;
    assign res_expect = exp_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;
endmodule

// File: tb/tb_loop_sum_checker.sv
// tb_loop_sum_checker: directed self-checking bench for loop_sum_checker
module tb_loop_sum_checker;
    localparam int W = 11;
    localparam int CNT_W = 8;
`ifdef STEP_CHECK_EN
    localparam logic STEP = 1'b1;
`else
    localparam logic STEP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, loop_rst, res_ready;
    logic [W-1:0] x_in, y_in, i_in, n_in;
    logic res_valid, res_pass, step_err;
    logic [W+1:0] res_sum, res_expect;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    loop_sum_checker #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .loop_rst(loop_rst),
        .x_in(x_in), .y_in(y_in), .i_in(i_in), .n_in(n_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_pass(res_pass),
        .res_sum(res_sum), .res_expect(res_expect), .step_err(step_err),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_loop(input int k, input int n);
        x_in = W'(k);
        y_in = W'(2 * k);
        i_in = W'(k);
        n_in = W'(n);
    endtask

    task automatic run_to_done(input int n, input int xlast);
        for (int k = 0; k < n; k++) begin
            set_loop(k, n);
            step();
        end
        set_loop(n, n);
        x_in = W'(xlast);
        step();
    endtask

    task automatic restart();
        loop_rst = 1'b1;
        set_loop(0, 40);
        step();
        loop_rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        loop_rst = 1'b1;
        res_ready = 1'b0;
        set_loop(0, 40);
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_pass", 32'(res_pass), 0);
        chk("rst_sum", 32'(res_sum), 0);
        chk("rst_expect", 32'(res_expect), 0);
        chk("rst_pass_cnt", 32'(pass_cnt), 0);
        chk("rst_fail_cnt", 32'(fail_cnt), 0);
        chk("rst_step_err", 32'(step_err), 0);

        restart();
        run_to_done(40, 40);
        chk("lat_t0_valid", 32'(res_valid), 0);
        step();
        chk("lat_t1_valid", 32'(res_valid), 0);
        step();
        chk("lat_t2_valid", 32'(res_valid), 1);
        chk("run1_sum", 32'(res_sum), 120);
        chk("run1_expect", 32'(res_expect), 120);
        chk("run1_pass", 32'(res_pass), 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("run1_valid_drop", 32'(res_valid), 0);
        chk("run1_pass_cnt", 32'(pass_cnt), 1);
        chk("run1_fail_cnt", 32'(fail_cnt), 0);

        restart();
        run_to_done(40, 40);
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_sum", 32'(res_sum), 120);
            chk("hold_pass_cnt", 32'(pass_cnt), 1);
            step();
        end
        chk("hold_valid_end", 32'(res_valid), 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("run2_valid_drop", 32'(res_valid), 0);
        chk("run2_pass_cnt", 32'(pass_cnt), 2);

        restart();
        for (int k = 0; k <= 20; k++) begin
            set_loop(k, 40);
            step();
        end
        loop_rst = 1'b1;
        step();
        loop_rst = 1'b0;
        chk("abort_valid", 32'(res_valid), 0);
        chk("abort_pass_cnt", 32'(pass_cnt), 2);
        res_ready = 1'b1;
        run_to_done(40, 40);
        step();
        step();
        chk("full_valid", 32'(res_valid), 1);
        step();
        res_ready = 1'b0;
        chk("full_pass_cnt", 32'(pass_cnt), 3);
        chk("full_fail_cnt", 32'(fail_cnt), 0);
        chk("full_valid_drop", 32'(res_valid), 0);

        restart();
        run_to_done(40, 41);
        step();
        step();
        chk("bad_valid", 32'(res_valid), 1);
        chk("bad_sum", 32'(res_sum), 121);
        chk("bad_expect", 32'(res_expect), 120);
        chk("bad_pass", 32'(res_pass), 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("bad_fail_cnt", 32'(fail_cnt), 1);
        chk("bad_pass_cnt", 32'(pass_cnt), 3);
        chk("bad_step_err", 32'(step_err), 32'(STEP));

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_step_err", 32'(step_err), 0);
        chk("rst2_fail_cnt", 32'(fail_cnt), 0);
        for (int k = 0; k <= 3; k++) begin
            set_loop(k, 10);
            step();
        end
        chk("step_good", 32'(step_err), 0);
        x_in = W'(4);
        y_in = W'(9);
        i_in = W'(4);
        n_in = W'(10);
        step();
        chk("step_jump", 32'(step_err), 32'(STEP));
        set_loop(5, 10);
        step();
        loop_rst = 1'b1;
        step();
        loop_rst = 1'b0;
        chk("step_sticky", 32'(step_err), 32'(STEP));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("step_rst_clear", 32'(step_err), 0);
        chk("rst3_pass_cnt", 32'(pass_cnt), 0);
        chk("rst3_sum", 32'(res_sum), 0);

        set_loop(0, 0);
        step();
        step();
        step();
        chk("n0_valid", 32'(res_valid), 1);
        chk("n0_sum", 32'(res_sum), 0);
        chk("n0_expect", 32'(res_expect), 0);
        chk("n0_pass", 32'(res_pass), 1);
        res_ready = 1'b1;
        step();
        chk("n0_pass_cnt", 32'(pass_cnt), 1);
        for (int r = 0; r < 254; r++) begin
            loop_rst = 1'b1;
            step();
            loop_rst = 1'b0;
            repeat (4) step();
        end
        chk("sat_pass_cnt", 32'(pass_cnt), 255);
        loop_rst = 1'b1;
        step();
        loop_rst = 1'b0;
        repeat (4) step();
        chk("sat_hold_cnt", 32'(pass_cnt), 255);
        chk("sat_fail_cnt", 32'(fail_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
